// File: rtl/midisynth_pkg.sv
// Shared constants and types for the synth command path.
package midisynth_pkg;

  // Command bytes carried in byte0 of a note frame.
  localparam logic [7:0] CMD_NOTE_ON  = 8'h90;
  localparam logic [7:0] CMD_NOTE_OFF = 8'h80;

  // A well-formed frame is exactly this many bits.
  localparam int FRAME_BITS = 56;

  // Bit counter value that marks "more bits than a frame holds".
  localparam logic [5:0] BIT_CNT_SAT = 6'd57;

  // Field widths shared with voice_controller.
  localparam int VOICE_W_DEF  = 8;
  localparam int TUNING_W_DEF = 32;

  // Receiver FSM states.
  typedef enum logic [1:0] {
    ST_WAIT_IDLE = 2'd0,
    ST_IDLE      = 2'd1,
    ST_SHIFT     = 2'd2,
    ST_CHECK     = 2'd3
  } rx_state_e;

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchroniser for an async pin, with a history flop for
// single-cycle rise/fall detection in the i_clk domain.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_din,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] chain_q, chain_d;
  logic              hist_q, hist_d;

  // Next-state of the synchroniser chain and the history flop.
  always_comb begin
    chain_d    = chain_q;
    chain_d[0] = i_din;
    for (int i = 1; i < STAGES; i++) begin
      chain_d[i] = chain_q[i-1];
    end
    hist_d = chain_q[STAGES-1];
  end

  // Register the chain; everything clears to 0 on reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      chain_q <= '0;
      hist_q  <= 1'b0;
    end else begin
      chain_q <= chain_d;
      hist_q  <= hist_d;
    end
  end

  assign o_level = chain_q[STAGES-1];
  assign o_rise  = chain_q[STAGES-1] & ~hist_q;
  assign o_fall  = ~chain_q[STAGES-1] & hist_q;

endmodule

// File: rtl/spi_note_receiver.sv
// SPI (mode 0) note-event receiver. Oversamples the SPI pins, shifts in a
// 56-bit frame while CS_n is low, validates it when CS_n rises and presents
// one registered note event per good frame.
//
// Output handshake: o_SPI_flag is a valid-only pulse (no ready). It is high
// for exactly one i_clk cycle, and the field outputs carry the new event in
// that same cycle and hold it until the next flag. o_frame_error is a
// one-cycle pulse for a discarded frame and is never high with o_SPI_flag.
module spi_note_receiver
  import midisynth_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int VOICE_W     = VOICE_W_DEF,
  parameter int TUNING_W    = TUNING_W_DEF
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_SCLK,
  input  logic                i_CS_n,
  input  logic                i_MOSI,
  output logic                o_SPI_flag,
  output logic                o_SPI_note_status,
  output logic [VOICE_W-1:0]  o_SPI_voice_index,
  output logic [TUNING_W-1:0] o_SPI_tuning_code,
  output logic [6:0]          o_SPI_velocity,
  output logic                o_frame_error,
  output logic                o_busy
);

  // Conditioned pin views.
  logic sclk_level, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;
  logic mosi_level;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_din   (i_SCLK),
    .o_level (sclk_level),
    .o_rise  (sclk_rise),
    .o_fall  (sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_din   (i_CS_n),
    .o_level (cs_level),
    .o_rise  (cs_rise),
    .o_fall  (cs_fall)
  );

  // Only the SCLK rising edge matters in mode 0.
  logic unused_sclk;
  assign unused_sclk = sclk_level ^ sclk_fall;

  // MOSI gets the same chain depth so it lines up with the SCLK edge pulse.
  logic [SYNC_STAGES-1:0] mosi_q, mosi_d;

  // Next-state of the MOSI delay chain.
  always_comb begin
    mosi_d    = mosi_q;
    mosi_d[0] = i_MOSI;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      mosi_d[i] = mosi_q[i-1];
    end
  end

  // Register the MOSI chain.
  always_ff @(posedge i_clk) begin
    if (i_reset) mosi_q <= '0;
    else         mosi_q <= mosi_d;
  end

  assign mosi_level = mosi_q[SYNC_STAGES-1];

  // FSM, frame capture and output registers. state_q is the observable
  // state for checkers.
  rx_state_e               state_q, state_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [5:0]              count_q, count_d;
  logic                    flag_q, flag_d;
  logic                    err_q, err_d;
  logic                    status_q, status_d;
  logic [VOICE_W-1:0]      voice_q, voice_d;
  logic [TUNING_W-1:0]     tuning_q, tuning_d;
  logic [6:0]              vel_q, vel_d;

  // Frame field views of the shift register.
  logic [7:0] f_cmd;
  logic [7:0] f_voice;
  logic [31:0] f_tuning;
  logic [7:0] f_vel;
  logic       frame_ok;

  assign f_cmd    = shift_q[55:48];
  assign f_voice  = shift_q[47:40];
  assign f_tuning = shift_q[39:8];
  assign f_vel    = shift_q[7:0];
  assign frame_ok = (count_q == 6'(FRAME_BITS)) &&
                    ((f_cmd == CMD_NOTE_ON) || (f_cmd == CMD_NOTE_OFF)) &&
                    !f_vel[7];

  // State transitions, shifting, validation and output loading.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    count_d  = count_q;
    flag_d   = 1'b0;
    err_d    = 1'b0;
    status_d = status_q;
    voice_d  = voice_q;
    tuning_d = tuning_q;
    vel_d    = vel_q;
    case (state_q)
      ST_WAIT_IDLE: begin
        // Do not trust CS_n until it has been seen high after reset.
        if (cs_level) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (cs_fall) begin
          shift_d = '0;
          count_d = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // End of frame wins over a coincident SCLK edge.
        if (cs_rise) begin
          state_d = ST_CHECK;
        end else if (sclk_rise) begin
          shift_d = {shift_q[FRAME_BITS-2:0], mosi_level};
          count_d = (count_q == BIT_CNT_SAT) ? BIT_CNT_SAT : count_q + 6'd1;
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        if (frame_ok) begin
          flag_d   = 1'b1;
          status_d = (f_cmd == CMD_NOTE_ON);
          voice_d  = VOICE_W'(f_voice);
          tuning_d = TUNING_W'(f_tuning);
          vel_d    = f_vel[6:0];
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = ST_WAIT_IDLE;
    endcase
  end

  // Register FSM state, capture datapath and outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_WAIT_IDLE;
      shift_q  <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
      err_q    <= 1'b0;
      status_q <= 1'b0;
      voice_q  <= '0;
      tuning_q <= '0;
      vel_q    <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
      err_q    <= err_d;
      status_q <= status_d;
      voice_q  <= voice_d;
      tuning_q <= tuning_d;
      vel_q    <= vel_d;
    end
  end

  assign o_SPI_flag        = flag_q;
  assign o_frame_error     = err_q;
  assign o_SPI_note_status = status_q;
  assign o_SPI_voice_index = voice_q;
  assign o_SPI_tuning_code = tuning_q;
  assign o_SPI_velocity    = vel_q;
  assign o_busy            = (state_q == ST_SHIFT);

endmodule
